tone_gen: RTL and testbench

//  Square-wave tone generator directly downstream of the score reader.

---
 rtl/tone_gen_if.sv | 21 ++
 rtl/tone_gen.sv | 140 ++++++++++++++
 tb/tb_tone_gen.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_gen_if.sv
// Note/band/mute bundle from the score reader into the tone generator,
// plus the buzzer and status lines coming back out.
interface tone_gen_if;
    logic [15:0] signal;
    logic [2:0]  band;
    logic        mute;
    logic        tone_out;
    logic [3:0]  note_idx;
    logic        playing;
    logic        multi_err;

    modport master (
        output signal, band, mute,
        input  tone_out, note_idx, playing, multi_err
    );

    modport slave (
        input  signal, band, mute,
        output tone_out, note_idx, playing, multi_err
    );
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator: one-hot note plus octave band in, 50% duty buzzer
// drive out, with pitch changes applied only at half-period boundaries.
module tone_gen #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int CNT_W    = 17,
    parameter int MIN_HALF = 2
) (
    input  logic       clk,
    input  logic       rst,
    tone_gen_if.slave  bus
);

    typedef enum logic {IDLE, PLAY} state_t;

    // Entries are tuned for 50 MHz; other clocks rescale them with rounding.
    function automatic logic [CNT_W-1:0] half_table(input logic [3:0] idx);
        logic [63:0] base;
        case (idx)
            4'd1:    base = 64'd95556;
            4'd2:    base = 64'd90193;
            4'd3:    base = 64'd85131;
            4'd4:    base = 64'd80353;
            4'd5:    base = 64'd75843;
            4'd6:    base = 64'd71586;
            4'd7:    base = 64'd67569;
            4'd8:    base = 64'd63776;
            4'd9:    base = 64'd60197;
            4'd10:   base = 64'd56818;
            4'd11:   base = 64'd53629;
            4'd12:   base = 64'd50619;
            4'd13:   base = 64'd47778;
            4'd14:   base = 64'd45097;
            4'd15:   base = 64'd42566;
            default: base = 64'd0;
        endcase
        if (CLK_HZ != 50_000_000)
            base = (base * 64'(CLK_HZ) + 64'd25_000_000) / 64'd50_000_000;
        return base[CNT_W-1:0];
    endfunction

    logic [15:0]      sig_q;
    logic [2:0]       band_q;
    logic             mute_q;
    logic [3:0]       req_idx;
    logic             multi_now;
    logic             multi_q;
    logic             multi_err_q;
    logic [CNT_W-1:0] half_shift;
    logic [CNT_W-1:0] half;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tone_q;
    logic [3:0]       note_q;
    logic             play_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= '0;
            band_q <= '0;
            mute_q <= 1'b0;
        end else begin
            sig_q  <= bus.signal;
            band_q <= bus.band;
            mute_q <= bus.mute;
        end
    end

    // Highest set note wins; bit 0 alone is treated as a rest.
    always_comb begin
        req_idx = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (sig_q[i])
                req_idx = 4'(i);
        end
    end

    always_comb begin
        multi_now  = ($countones(sig_q[15:1]) > 1);
        half_shift = half_table(req_idx) >> band_q;
        half       = (half_shift < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : half_shift;
    end

    // Pulse once on entry into a multi-hot vector rather than for as long as it is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_q     <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            multi_q     <= multi_now;
            multi_err_q <= multi_now && !multi_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            tone_q <= 1'b0;
            note_q <= 4'd0;
            play_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_idx != 4'd0 && !mute_q) begin
                        tone_q <= 1'b1;
                        cnt    <= half - CNT_W'(1);
                        note_q <= req_idx;
                        play_q <= 1'b1;
                        state  <= PLAY;
                    end
                end
                PLAY: begin
                    // Inputs are only looked at here, so pitch changes stay phase-continuous.
                    if (cnt == '0) begin
                        if (mute_q || req_idx == 4'd0) begin
                            tone_q <= 1'b0;
                            note_q <= 4'd0;
                            play_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            tone_q <= ~tone_q;
                            cnt    <= half - CNT_W'(1);
                            note_q <= req_idx;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tone_out  = tone_q;
    assign bus.note_idx  = note_q;
    assign bus.playing   = play_q;
    assign bus.multi_err = multi_err_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: directed scenarios plus random note/band/mute traffic,
// all checked every cycle against a boundary-time reference model.
module tb_tone_gen;

    logic clk = 1'b0;
    logic rst;

    tone_gen_if bus();

    tone_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checksDone   = 0;
    int checksPassed = 0;

    int tbl [16] = '{0, 95556, 90193, 85131, 80353, 75843, 71586, 67569,
                     63776, 60197, 56818, 53629, 50619, 47778, 45097, 42566};

    // Reference model: registered inputs and the absolute cycle of the next boundary.
    logic [15:0] regSig;
    logic [2:0]  regBand;
    logic        regMute;
    logic        mTone;
    int          mNote;
    logic        mPlaying;
    logic        mMulti;
    logic        lastMulti;
    longint      cyc;
    longint      boundaryAt;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checksDone++;
        if (observed == expected)
            checksPassed++;
        else
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    endtask

    function automatic int highestNote(input logic [15:0] s);
        for (int k = 15; k >= 1; k--)
            if (s[k]) return k;
        return 0;
    endfunction

    function automatic int bitsAboveZero(input logic [15:0] s);
        int n = 0;
        for (int k = 1; k < 16; k++)
            if (s[k]) n++;
        return n;
    endfunction

    function automatic int halfFor(input int note, input int shift);
        int h = tbl[note] >> shift;
        return (h < 2) ? 2 : h;
    endfunction

    task automatic modelReset();
        regSig     = '0;
        regBand    = '0;
        regMute    = 1'b0;
        mTone      = 1'b0;
        mNote      = 0;
        mPlaying   = 1'b0;
        mMulti     = 1'b0;
        lastMulti  = 1'b0;
        boundaryAt = 0;
    endtask

    task automatic stepModel();
        int  note;
        bit  isMulti;
        cyc++;
        if (rst) begin
            modelReset();
            return;
        end
        note    = highestNote(regSig);
        isMulti = bitsAboveZero(regSig) > 1;
        mMulti  = isMulti && !lastMulti;
        lastMulti = isMulti;
        if (!mPlaying) begin
            if (note != 0 && !regMute) begin
                mTone      = 1'b1;
                mNote      = note;
                mPlaying   = 1'b1;
                boundaryAt = cyc + longint'(halfFor(note, int'(regBand)));
            end
        end else if (cyc == boundaryAt) begin
            if (regMute || note == 0) begin
                mTone    = 1'b0;
                mNote    = 0;
                mPlaying = 1'b0;
            end else begin
                mTone      = ~mTone;
                mNote      = note;
                boundaryAt = cyc + longint'(halfFor(note, int'(regBand)));
            end
        end
        regSig  = bus.signal;
        regBand = bus.band;
        regMute = bus.mute;
    endtask

    task automatic checkAll();
        checkOutput("tone_out",  longint'(bus.tone_out),  longint'(mTone));
        checkOutput("note_idx",  longint'(bus.note_idx),  longint'(mNote));
        checkOutput("playing",   longint'(bus.playing),   longint'(mPlaying));
        checkOutput("multi_err", longint'(bus.multi_err), longint'(mMulti));
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            stepModel();
            @(negedge clk);
            checkAll();
        end
    endtask

    task automatic runUntilToggle(input int limit, output int len);
        logic startVal;
        startVal = bus.tone_out;
        len = 0;
        while (bus.tone_out == startVal && len < limit) begin
            runCycles(1);
            len++;
        end
        if (bus.tone_out == startVal)
            checkOutput("toggleTimeout", longint'(len), -1);
    endtask

    task automatic applyStimulus(input logic [15:0] sig, input logic [2:0] bnd, input logic mt);
        bus.signal = sig;
        bus.band   = bnd;
        bus.mute   = mt;
    endtask

    task automatic applyReset();
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rstTone",  longint'(bus.tone_out),  0);
        checkOutput("rstNote",  longint'(bus.note_idx),  0);
        checkOutput("rstPlay",  longint'(bus.playing),   0);
        checkOutput("rstMulti", longint'(bus.multi_err), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int len;
        logic [15:0] rs;
        int kind;
        rst = 1'b1;
        cyc = 0;
        modelReset();
        applyStimulus(16'h0000, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        applyReset();

        // Note 10, band 2: two-cycle latency, half = 14204
        applyStimulus(16'h0400, 3'd2, 1'b0);
        runCycles(1);
        checkOutput("latencyLow", longint'(bus.tone_out), 0);
        runCycles(1);
        checkOutput("latencyHigh", longint'(bus.tone_out), 1);
        checkOutput("noteIdx10", longint'(bus.note_idx), 10);
        runUntilToggle(20000, len);
        checkOutput("halfNote10", longint'(len), 14204);

        // Mid-half switch to note 12: old half finishes, then 50619>>2
        runCycles(100);
        applyStimulus(16'h1000, 3'd2, 1'b0);
        runUntilToggle(20000, len);
        checkOutput("oldHalfDone", longint'(len), 14104);
        checkOutput("noteIdx12", longint'(bus.note_idx), 12);
        runUntilToggle(20000, len);
        checkOutput("halfNote12", longint'(len), 12654);

        // Note 1 at band 3: period 23888
        applyStimulus(16'h0002, 3'd3, 1'b0);
        runUntilToggle(20000, len);
        runUntilToggle(20000, len);
        checkOutput("halfNote1a", longint'(len), 11944);
        begin
            int len2;
            runUntilToggle(20000, len2);
            checkOutput("periodNote1", longint'(len + len2), 23888);
        end

        // Rest during PLAY stops at the next boundary; band 7 on note 15 gives 332
        applyStimulus(16'h8000, 3'd7, 1'b0);
        runUntilToggle(20000, len);
        runUntilToggle(1000, len);
        checkOutput("halfNote15b7", longint'(len), 332);
        runCycles(50);
        applyStimulus(16'h0000, 3'd7, 1'b0);
        runUntilToggle(1000, len);
        checkOutput("restStopPlay", longint'(bus.playing), 0);
        checkOutput("restStopNote", longint'(bus.note_idx), 0);

        // Mute mid-half, then release with note held
        runCycles(5);
        applyStimulus(16'h8000, 3'd7, 1'b0);
        runCycles(2);
        checkOutput("restartHigh", longint'(bus.tone_out), 1);
        runCycles(10);
        applyStimulus(16'h8000, 3'd7, 1'b1);
        runUntilToggle(1000, len);
        checkOutput("muteHalfLen", longint'(len), 322);
        runCycles(20);
        checkOutput("mutedIdle", longint'(bus.playing), 0);
        applyStimulus(16'h8000, 3'd7, 1'b0);
        runCycles(2);
        checkOutput("unmuteRestart", longint'(bus.playing), 1);

        // Multi-hot vector, then bit-0-only rest
        applyStimulus(16'h0000, 3'd7, 1'b0);
        runUntilToggle(1000, len);
        runCycles(3);
        applyStimulus(16'h0022, 3'd7, 1'b0);
        runCycles(1);
        checkOutput("multiBefore", longint'(bus.multi_err), 0);
        runCycles(1);
        checkOutput("multiPulse", longint'(bus.multi_err), 1);
        checkOutput("multiNote5", longint'(bus.note_idx), 5);
        runCycles(1);
        checkOutput("multiAfter", longint'(bus.multi_err), 0);
        applyStimulus(16'h0001, 3'd7, 1'b0);
        runUntilToggle(1000, len);
        runCycles(5);
        checkOutput("bit0Idle", longint'(bus.playing), 0);

        // Async reset mid-tone and clean restart
        applyStimulus(16'h8000, 3'd5, 1'b0);
        runCycles(2);
        runCycles(100);
        applyReset();
        runCycles(1);
        checkOutput("postRstLow", longint'(bus.tone_out), 0);
        runCycles(1);
        checkOutput("postRstHigh", longint'(bus.tone_out), 1);
        runUntilToggle(5000, len);
        checkOutput("halfNote15b5", longint'(len), 1330);

        // Random traffic
        for (int s = 0; s < 20; s++) begin
            kind = int'($urandom_range(0, 9));
            rs = 16'($urandom_range(0, 65535));
            case (kind)
                0, 1, 2, 3, 4, 5:
                    applyStimulus(16'h0001 << $urandom_range(1, 15), 3'($urandom_range(5, 7)), 1'b0);
                6:
                    applyStimulus(16'($urandom_range(0, 1)), 3'($urandom_range(5, 7)), 1'b0);
                7:
                    applyStimulus(rs | 16'h0006, 3'($urandom_range(5, 7)), 1'b0);
                8:
                    applyStimulus(16'h0001 << $urandom_range(1, 15), 3'($urandom_range(5, 7)), 1'b1);
                default:
                    applyStimulus(rs, 3'($urandom_range(5, 7)), 1'($urandom_range(0, 1)));
            endcase
            runCycles(int'($urandom_range(20, 1200)));
        end

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
